// File: rtl/aes_req_arbiter.sv
// Round-robin arbiter sharing one AES-128 core between NUM_REQ requesters.
// A tag FIFO records issue order so each in-order ciphertext returns to its owner.
module aes_req_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_W       = 128,
  parameter int unsigned KEY_L        = 128,
  parameter int unsigned MAX_INFLIGHT = 16,
  parameter int unsigned IDW          = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*KEY_L-1:0]  req_key,
  input  logic [NUM_REQ*DATA_W-1:0] req_text,
  output logic                      rsp_valid,
  output logic [IDW-1:0]            rsp_id,
  output logic [DATA_W-1:0]         rsp_text,
  output logic                      core_valid_in,
  output logic [KEY_L-1:0]          core_key,
  output logic [DATA_W-1:0]         core_text,
  input  logic [DATA_W-1:0]         core_cipher_text,
  input  logic                      core_valid_out,
  output logic                      busy,
  output logic                      err_unexpected
);

  localparam int unsigned PtrW = $clog2(MAX_INFLIGHT);
  localparam int unsigned CntW = PtrW + 1;

  logic [IDW-1:0]    ptr_q;
  logic [CntW-1:0]   inflight_q;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [IDW-1:0]    tag_mem_q [MAX_INFLIGHT];

  logic              core_valid_in_q;
  logic [KEY_L-1:0]  core_key_q;
  logic [DATA_W-1:0] core_text_q;
  logic              rsp_valid_q;
  logic [IDW-1:0]    rsp_id_q;
  logic [DATA_W-1:0] rsp_text_q;
  logic              err_q;

  logic [KEY_L-1:0]  key_arr  [NUM_REQ];
  logic [DATA_W-1:0] text_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign key_arr[g]  = req_key[g*KEY_L +: KEY_L];
    assign text_arr[g] = req_text[g*DATA_W +: DATA_W];
  end

  logic           can_issue;
  logic           found;
  logic [IDW-1:0] winner;
  logic           transfer;
  logic           pop;
  logic           unexpected;

  assign can_issue = (inflight_q < CntW'(MAX_INFLIGHT));

  // Scan from the requester after the last winner, wrapping around.
  always_comb begin : arb
    logic [IDW-1:0] idx;
    idx    = '0;
    found  = 1'b0;
    winner = '0;
    for (int off = 1; off <= int'(NUM_REQ); off++) begin
      idx = IDW'((int'(ptr_q) + off) % int'(NUM_REQ));
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (found) req_ready[winner] = can_issue;
  end

  assign transfer   = found & can_issue;
  // The counter doubles as the FIFO occupancy, so empty means nothing inflight.
  assign pop        = core_valid_out & (inflight_q != '0);
  assign unexpected = core_valid_out & (inflight_q == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q           <= IDW'(NUM_REQ - 1);
      inflight_q      <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      for (int i = 0; i < int'(MAX_INFLIGHT); i++) tag_mem_q[i] <= '0;
      core_valid_in_q <= 1'b0;
      core_key_q      <= '0;
      core_text_q     <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_id_q        <= '0;
      rsp_text_q      <= '0;
      err_q           <= 1'b0;
    end else begin
      core_valid_in_q <= transfer;
      if (transfer) begin
        core_key_q          <= key_arr[winner];
        core_text_q         <= text_arr[winner];
        ptr_q               <= winner;
        tag_mem_q[wr_ptr_q] <= winner;
        wr_ptr_q            <= wr_ptr_q + PtrW'(1);
      end

      rsp_valid_q <= pop;
      if (pop) begin
        rsp_id_q   <= tag_mem_q[rd_ptr_q];
        rsp_text_q <= core_cipher_text;
        rd_ptr_q   <= rd_ptr_q + PtrW'(1);
      end

      unique case ({transfer, pop})
        2'b10:   inflight_q <= inflight_q + CntW'(1);
        2'b01:   inflight_q <= inflight_q - CntW'(1);
        default: inflight_q <= inflight_q;
      endcase

      if (unexpected) err_q <= 1'b1;
    end
  end

  assign core_valid_in  = core_valid_in_q;
  assign core_key       = core_key_q;
  assign core_text      = core_text_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_id         = rsp_id_q;
  assign rsp_text       = rsp_text_q;
  assign busy           = (inflight_q != '0);
  assign err_unexpected = err_q;

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Scoreboard bench for aes_req_arbiter with a behavioural fixed-latency core model.
module tb_aes_req_arbiter;

  localparam int NR = 4;
  localparam int DW = 128;
  localparam int KL = 128;
  localparam int MI = 4;
  localparam int IW = 2;

  localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*KL-1:0] req_key;
  logic [NR*DW-1:0] req_text;
  logic             rsp_valid;
  logic [IW-1:0]    rsp_id;
  logic [DW-1:0]    rsp_text;
  logic             core_valid_in;
  logic [KL-1:0]    core_key;
  logic [DW-1:0]    core_text;
  logic [DW-1:0]    core_cipher_text;
  logic             core_valid_out;
  logic             busy;
  logic             err_unexpected;

  aes_req_arbiter #(
    .NUM_REQ(NR), .DATA_W(DW), .KEY_L(KL), .MAX_INFLIGHT(MI), .IDW(IW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key), .req_text(req_text),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_text(rsp_text),
    .core_valid_in(core_valid_in), .core_key(core_key), .core_text(core_text),
    .core_cipher_text(core_cipher_text), .core_valid_out(core_valid_out),
    .busy(busy), .err_unexpected(err_unexpected)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic [KL-1:0] key_a  [NR];
  logic [DW-1:0] text_a [NR];
  int            n_a    [NR];

  always_comb begin
    req_key  = '0;
    req_text = '0;
    for (int i = 0; i < NR; i++) begin
      req_key[i*KL +: KL]  = key_a[i];
      req_text[i*DW +: DW] = text_a[i];
    end
  end

  function automatic logic [127:0] mk_key(int i, int n);
    return {4{8'(i), 8'(n), 16'hA55A}};
  endfunction

  function automatic logic [127:0] mk_text(int i, int n);
    return {4{16'hC0DE, 8'(n), 8'(i)}};
  endfunction

  // Core stand-in: the FIPS-197 vector maps to its real ciphertext, anything else is scrambled.
  function automatic logic [127:0] core_f(logic [127:0] k, logic [127:0] t);
    if (k == K0 && t == P0) return C0;
    return k ^ t ^ {4{32'hDEADBEEF}};
  endfunction

  logic [4:0]    core_lat = 5'd10;
  logic          inj = 1'b0;
  logic [31:0]   pipe_v = '0;
  logic [DW-1:0] pipe_d [32];

  always @(posedge clk) begin
    pipe_v    <= {pipe_v[30:0], core_valid_in};
    pipe_d[0] <= core_f(core_key, core_text);
    for (int i = 1; i < 32; i++) pipe_d[i] <= pipe_d[i-1];
  end

  assign core_valid_out   = pipe_v[core_lat - 5'd1] | inj;
  assign core_cipher_text = pipe_d[core_lat - 5'd1];

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] text;
    int            cyc;
  } exp_t;

  exp_t sb_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic load(input int i);
    key_a[i]  = mk_key(i, n_a[i]);
    text_a[i] = mk_text(i, n_a[i]);
  endtask

  task automatic advance(input int i);
    n_a[i]++;
    load(i);
  endtask

  // Called in the handshake cycle; the response is due lat+2 cycles later.
  task automatic push_exp(input int i);
    exp_t e;
    e.id   = IW'(i);
    e.text = core_f(key_a[i], text_a[i]);
    e.cyc  = cyc + int'(core_lat) + 2;
    sb_q.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp_unexpected: got rsp_id=%0d rsp_text=%h expected no response (cycle %0d)",
                   rsp_id, rsp_text, cyc);
        end else begin
          e = sb_q.pop_front();
          chk("rsp_id", 128'(rsp_id), 128'(e.id));
          chk("rsp_text", rsp_text, e.text);
          chk("rsp_cycle", 128'(cyc), 128'(e.cyc));
        end
      end
    end
  endtask

  // Waits for outstanding responses, then lets the core model pipeline empty.
  task automatic drain();
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(posedge clk);
    chk("drain_pending", 128'(sb_q.size()), 128'(0));
    repeat (34) @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 128'(req_ready), 128'(0));
    chk({tag, "_core_valid_in"}, 128'(core_valid_in), 128'(0));
    chk({tag, "_core_key"}, core_key, 128'(0));
    chk({tag, "_core_text"}, core_text, 128'(0));
    chk({tag, "_rsp_valid"}, 128'(rsp_valid), 128'(0));
    chk({tag, "_rsp_id"}, 128'(rsp_id), 128'(0));
    chk({tag, "_rsp_text"}, rsp_text, 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_err"}, 128'(err_unexpected), 128'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit acc;
    fork
      monitor();
    join_none

    req_valid = '0;
    for (int i = 0; i < NR; i++) begin
      n_a[i] = 0;
      load(i);
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1 chk_all_zero("reset");
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Fairness: all requesters held valid, short core latency
    core_lat = 5'd1;
    @(posedge clk);
    #1 req_valid = '1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("fair_grant", 128'(req_ready), 128'(1 << (k % NR)));
      push_exp(k % NR);
      @(posedge clk);
      #1 advance(k % NR);
    end
    req_valid = '0;
    drain();

    // Single request with the FIPS-197 vector
    core_lat = 5'd10;
    key_a[0]  = K0;
    text_a[0] = P0;
    req_valid = 4'b0001;
    @(negedge clk);
    chk("single_ready", 128'(req_ready), 128'(4'b0001));
    push_exp(0);
    @(posedge clk);
    #1 req_valid = '0;
    chk("single_core_valid_in", 128'(core_valid_in), 128'(1));
    chk("single_core_key", core_key, K0);
    chk("single_core_text", core_text, P0);
    chk("single_busy", 128'(busy), 128'(1));
    @(posedge clk);
    #1 chk("single_core_valid_in_pulse", 128'(core_valid_in), 128'(0));
    load(0);
    drain();

    // Credit limit: MAX_INFLIGHT=4, latency 20, requester 1 always valid
    core_lat = 5'd20;
    req_valid = 4'b0010;
    for (int t = 0; t < 31; t++) begin
      acc = (t <= 3) || (t >= 22 && t <= 25);
      @(negedge clk);
      chk("credit_ready", 128'(req_ready), acc ? 128'(4'b0010) : 128'(0));
      if (acc) push_exp(1);
      @(posedge clk);
      #1 if (acc) advance(1);
    end
    req_valid = '0;
    drain();
    core_lat = 5'd10;

    // Unexpected return with nothing inflight
    inj = 1'b1;
    @(posedge clk);
    #1 inj = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("unexp_err", 128'(err_unexpected), 128'(1));
      chk("unexp_rsp_valid", 128'(rsp_valid), 128'(0));
    end
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 chk("unexp_err_after_reset", 128'(err_unexpected), 128'(0));
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset with three blocks outstanding
    req_valid = 4'b0111;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mid_grant", 128'(req_ready), 128'(1 << k));
      @(posedge clk);
      #1 advance(k);
      req_valid[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #2 chk("mid_busy_before_reset", 128'(busy), 128'(1));
    reset_n = 1'b0;
    #1 chk_all_zero("mid_reset");
    @(posedge clk);
    #1 reset_n = 1'b1;
    // Stale results drain out of the core and must be dropped
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("stale_rsp_valid", 128'(rsp_valid), 128'(0));
    end
    chk("stale_err", 128'(err_unexpected), 128'(1));

    @(posedge clk);
    #1 req_valid = 4'b1001;
    @(negedge clk);
    chk("post_reset_grant", 128'(req_ready), 128'(4'b0001));
    push_exp(0);
    @(posedge clk);
    #1 advance(0);
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("post_reset_grant2", 128'(req_ready), 128'(4'b1000));
    push_exp(3);
    @(posedge clk);
    #1 advance(3);
    req_valid = '0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
